// File: rtl/teclado_matricial.sv
// 4x4 matrix keypad scanner: synchronises and debounces the rows, then turns each
// accepted press into a single-cycle event for the calculator control FSM.
module teclado_matricial #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] filas,
  output logic [3:0] columnas,
  output logic [3:0] digito,
  output logic       digito_en,
  output logic       operando_en,
  output logic [1:0] que_operacion,
  output logic       igual_en,
  output logic       borrar_en
);

  localparam int DIV_W = $clog2(SCAN_DIV) + 1;
  localparam int CNT_W = $clog2(DEBOUNCE) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_TOP  = CNT_W'(DEBOUNCE);

  typedef enum logic [1:0] {ESCANEAR, VALIDAR, EMITIR, ESPERAR_SOLTAR} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       filas_meta_reg, filas_sync_reg;
  logic [DIV_W-1:0] div_reg;
  logic [1:0]       col_idx_reg, col_idx_next;
  logic [1:0]       cand_row_reg, cand_row_next;
  logic [CNT_W-1:0] deb_cnt_reg, deb_cnt_next;
  logic [CNT_W-1:0] rel_cnt_reg, rel_cnt_next;
  logic [3:0]       digito_reg, digito_next;
  logic [1:0]       que_op_reg, que_op_next;
  // strobe bit order: {digito, operando, igual, borrar}
  logic [3:0]       strobe_reg, strobe_next;

  logic       sample;
  logic       any_low;
  logic [1:0] low_row;
  logic [1:0] emit_row;
  logic       load;
  logic [3:0] digit_val;

  assign sample  = (div_reg == DIV_LAST);
  assign any_low = ~&filas_sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      filas_meta_reg <= 4'b1111;
      filas_sync_reg <= 4'b1111;
    end else begin
      filas_meta_reg <= filas;
      filas_sync_reg <= filas_meta_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || sample) div_reg <= '0;
    else                 div_reg <= div_reg + DIV_W'(1);
  end

  // Lowest-indexed low row wins when several rows are pressed.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!filas_sync_reg[i]) low_row = 2'(i);
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign columnas[gi] = (col_idx_reg != 2'(gi));
    end
  endgenerate

  assign digit_val = ({2'b00, emit_row} * 4'd3) + {2'b00, col_idx_reg} + 4'd1;

  always_comb begin
    state_next    = state_reg;
    col_idx_next  = col_idx_reg;
    cand_row_next = cand_row_reg;
    deb_cnt_next  = deb_cnt_reg;
    rel_cnt_next  = rel_cnt_reg;
    digito_next   = digito_reg;
    que_op_next   = que_op_reg;
    strobe_next   = 4'b0000;
    emit_row      = cand_row_reg;
    load          = 1'b0;

    case (state_reg)
      ESCANEAR: begin
        if (sample) begin
          if (any_low) begin
            cand_row_next = low_row;
            deb_cnt_next  = CNT_W'(1);
            if (DEBOUNCE == 1) begin
              state_next = EMITIR;
              emit_row   = low_row;
              load       = 1'b1;
            end else begin
              state_next = VALIDAR;
            end
          end else begin
            col_idx_next = col_idx_reg + 2'd1;
          end
        end
      end
      VALIDAR: begin
        if (sample) begin
          if (any_low && (low_row == cand_row_reg)) begin
            deb_cnt_next = deb_cnt_reg + CNT_W'(1);
            if (deb_cnt_reg + CNT_W'(1) == DEB_TOP) begin
              state_next = EMITIR;
              load       = 1'b1;
            end
          end else begin
            state_next   = ESCANEAR;
            col_idx_next = col_idx_reg + 2'd1;
          end
        end
      end
      EMITIR: begin
        state_next   = ESPERAR_SOLTAR;
        rel_cnt_next = '0;
      end
      ESPERAR_SOLTAR: begin
        if (sample) begin
          if (!any_low) begin
            rel_cnt_next = rel_cnt_reg + CNT_W'(1);
            if (rel_cnt_reg + CNT_W'(1) == DEB_TOP) begin
              state_next   = ESCANEAR;
              col_idx_next = col_idx_reg + 2'd1;
            end
          end else begin
            rel_cnt_next = '0;
          end
        end
      end
      default: state_next = ESCANEAR;
    endcase

    // Outputs are registered on entry to EMITIR so the strobe and its held
    // value appear together for exactly the EMITIR cycle.
    if (load) begin
      if (col_idx_reg == 2'd3) begin
        strobe_next = 4'b0100;
        que_op_next = emit_row;
      end else if (emit_row == 2'd3) begin
        case (col_idx_reg)
          2'd0:    strobe_next = 4'b0001;
          2'd2:    strobe_next = 4'b0010;
          default: begin
            strobe_next = 4'b1000;
            digito_next = 4'd0;
          end
        endcase
      end else begin
        strobe_next = 4'b1000;
        digito_next = digit_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ESCANEAR;
      col_idx_reg  <= 2'd0;
      cand_row_reg <= 2'd0;
      deb_cnt_reg  <= '0;
      rel_cnt_reg  <= '0;
      digito_reg   <= 4'd0;
      que_op_reg   <= 2'b00;
      strobe_reg   <= 4'b0000;
    end else begin
      state_reg    <= state_next;
      col_idx_reg  <= col_idx_next;
      cand_row_reg <= cand_row_next;
      deb_cnt_reg  <= deb_cnt_next;
      rel_cnt_reg  <= rel_cnt_next;
      digito_reg   <= digito_next;
      que_op_reg   <= que_op_next;
      strobe_reg   <= strobe_next;
    end
  end

  assign digito        = digito_reg;
  assign que_operacion = que_op_reg;
  assign digito_en     = strobe_reg[3];
  assign operando_en   = strobe_reg[2];
  assign igual_en      = strobe_reg[1];
  assign borrar_en     = strobe_reg[0];

endmodule

// File: tb/tb_teclado_matricial.sv
// Bench for teclado_matricial: physical keypad model, cycle reference model of the
// scanner, per-cycle output comparison plus directed literal expectations.
module tb_teclado_matricial;

  localparam int SD  = 4;
  localparam int DEB = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] filas;
  logic [3:0] columnas;
  logic [3:0] digito;
  logic       digito_en, operando_en, igual_en, borrar_en;
  logic [1:0] que_operacion;

  teclado_matricial #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
    .clk(clk), .reset(reset), .filas(filas), .columnas(columnas),
    .digito(digito), .digito_en(digito_en), .operando_en(operando_en),
    .que_operacion(que_operacion), .igual_en(igual_en), .borrar_en(borrar_en)
  );

  always #5 clk = ~clk;

  // keys[r*4+c] = 1 means key at row r, column c is held down.
  logic [15:0] keys;
  always_comb begin
    filas = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !columnas[c]) filas[r] = 1'b0;
  end

  // ---------------- reference model ----------------
  localparam int M_SCAN = 0, M_VAL = 1, M_EMIT = 2, M_WAIT = 3;
  byte  keymap [16] = '{"1","2","3","A","4","5","6","B","7","8","9","C","*","0","#","D"};
  logic [3:0] m_s1, m_s2, rows;
  int   m_div, m_col, m_mode, m_cnt, m_row, low;
  bit   smp;
  byte  ch;
  logic [3:0] e_cols, e_dig, e_strb;
  logic [1:0] e_op;

  function automatic int lowest(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (!r[i]) return i;
    return -1;
  endfunction

  task automatic model_emit();
    ch = keymap[m_row*4 + m_col];
    if (ch >= 8'h30 && ch <= 8'h39) begin e_dig = 4'(ch - 8'h30); e_strb = 4'b1000; end
    else if (ch >= 8'h41 && ch <= 8'h44) begin e_op = 2'(ch - 8'h41); e_strb = 4'b0100; end
    else if (ch == 8'h23) e_strb = 4'b0010;
    else e_strb = 4'b0001;
    m_mode = M_EMIT;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_div = 0; m_col = 0; m_mode = M_SCAN;
      m_cnt = 0; m_row = 0; e_dig = 4'd0; e_op = 2'd0; e_strb = 4'd0;
    end else begin
      rows = m_s2;
      low = lowest(rows);
      smp = (m_div == SD - 1);
      m_div = smp ? 0 : m_div + 1;
      e_strb = 4'd0;
      case (m_mode)
        M_SCAN: if (smp) begin
          if (low >= 0) begin
            m_row = low; m_cnt = 1;
            if (m_cnt >= DEB) model_emit(); else m_mode = M_VAL;
          end else m_col = (m_col + 1) % 4;
        end
        M_VAL: if (smp) begin
          if (low == m_row) begin
            m_cnt++;
            if (m_cnt == DEB) model_emit();
          end else begin
            m_mode = M_SCAN; m_col = (m_col + 1) % 4;
          end
        end
        M_EMIT: begin m_mode = M_WAIT; m_cnt = 0; end
        default: if (smp) begin
          if (low < 0) begin
            m_cnt++;
            if (m_cnt == DEB) begin m_mode = M_SCAN; m_col = (m_col + 1) % 4; end
          end else m_cnt = 0;
        end
      endcase
      m_s2 = m_s1;
      m_s1 = filas;
    end
    e_cols = 4'hF & ~(4'h1 << m_col);
  end

  // ---------------- checking ----------------
  int tests_run = 0;
  int fails = 0;
  int dig_cnt = 0, op_cnt = 0, ig_cnt = 0, bor_cnt = 0;
  int dig_at = -1, op_at = -1;
  int d0, o0, g0, b0, lat;
  logic [13:0] got_v, exp_v;
  logic [3:0] rot [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

  task automatic check(input string name, input int got, input int expv);
    tests_run++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, expv, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_columnas"}, int'(columnas), 14);
    check({tag, "_strobes"}, int'({digito_en, operando_en, igual_en, borrar_en}), 0);
    check({tag, "_digito"}, int'(digito), 0);
    check({tag, "_que_op"}, int'(que_operacion), 0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    keys  = 16'h0;
    reset = 1'b1;
    wait_cycles(3);

    fork
      forever begin
        @(negedge clk);
        got_v = {columnas, digito, que_operacion, digito_en, operando_en, igual_en, borrar_en};
        exp_v = {e_cols, e_dig, e_op, e_strb};
        tests_run++;
        if (got_v !== exp_v) begin
          fails++;
          $display("FAIL cycle_outputs got=%h expected=%h at %0t", got_v, exp_v, $time);
        end
        if (digito_en)   begin dig_cnt++; dig_at = int'(digito); end
        if (operando_en) begin op_cnt++;  op_at  = int'(que_operacion); end
        if (igual_en)    ig_cnt++;
        if (borrar_en)   bor_cnt++;
      end
    join_none

    // 1: reset values and free-running column rotation
    check_reset_vals("rst");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_cycles(SD);
      check("scan_rotation", int'(columnas), int'(rot[i]));
    end
    $display("[TB] reset and scan rotation done");

    // 2: hold '5'
    d0 = dig_cnt;
    keys[5] = 1'b1;
    wait_cycles(200);
    check("hold5_columnas", int'(columnas), 13);
    check("hold5_pulses", dig_cnt - d0, 1);
    check("hold5_digito_at_strobe", dig_at, 5);
    check("hold5_digito_held", int'(digito), 5);
    keys = 16'h0;
    wait_cycles(40);
    $display("[TB] key 5 held: %0d digit pulses", dig_cnt - d0);

    // 3: 'C' then '#'
    o0 = op_cnt; g0 = ig_cnt;
    keys[11] = 1'b1; wait_cycles(60); keys = 16'h0; wait_cycles(40);
    keys[14] = 1'b1; wait_cycles(60); keys = 16'h0; wait_cycles(40);
    check("opC_pulses", op_cnt - o0, 1);
    check("opC_code_at_strobe", op_at, 2);
    check("igual_pulses", ig_cnt - g0, 1);
    check("que_op_held", int'(que_operacion), 2);
    check("digito_unchanged", int'(digito), 5);
    $display("[TB] C then #: op=%0d igual=%0d", op_cnt - o0, ig_cnt - g0);

    // 4: single-sample bounce on column 0
    d0 = dig_cnt + op_cnt + ig_cnt + bor_cnt;
    lat = 0;
    while (columnas == 4'b1110 && lat < 40) begin @(negedge clk); lat++; end
    while (columnas != 4'b1110 && lat < 80) begin @(negedge clk); lat++; end
    check("bounce_find_col0", int'(columnas), 14);
    keys[0] = 1'b1; wait_cycles(3); keys = 16'h0; wait_cycles(5);
    check("bounce_advance", int'(columnas), 13);
    wait_cycles(SD);
    check("bounce_rescan", int'(columnas), 11);
    check("bounce_no_strobe", dig_cnt + op_cnt + ig_cnt + bor_cnt - d0, 0);
    $display("[TB] bounce: columnas=%b", columnas);

    // 5: '1' and '4' together, glitchy release, re-press
    d0 = dig_cnt;
    keys[0] = 1'b1; keys[4] = 1'b1;
    wait_cycles(60);
    check("multi_pulses", dig_cnt - d0, 1);
    check("multi_digito", dig_at, 1);
    keys = 16'h0; wait_cycles(5);
    keys[0] = 1'b1; wait_cycles(4); keys = 16'h0;
    wait_cycles(40);
    check("glitch_no_second", dig_cnt - d0, 1);
    keys[0] = 1'b1; wait_cycles(60);
    check("repress_pulse", dig_cnt - d0, 2);
    keys = 16'h0; wait_cycles(40);
    $display("[TB] multi-key/glitch: %0d digit pulses", dig_cnt - d0);

    // 6: '*' held across a reset in the release-wait state
    b0 = bor_cnt;
    keys[12] = 1'b1; wait_cycles(60);
    check("borrar_first", bor_cnt - b0, 1);
    reset = 1'b1; wait_cycles(2);
    check_reset_vals("midrst");
    reset = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (borrar_en && lat < 0) lat = k;
    end
    check("borrar_latency", lat, 12);
    wait_cycles(20);
    check("borrar_after_reset", bor_cnt - b0, 2);
    keys = 16'h0; wait_cycles(40);
    $display("[TB] reset while held: borrar latency %0d", lat);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/teclado_matricial.md
Name: teclado_matricial

Overview:
Scans a 4x4 matrix keypad, synchronises and debounces the row inputs, and decodes each validated press into exactly one single-cycle event for the calculator control FSM that sits directly downstream. Event types are digit entry, operator selection, equals and clear. Operator presses carry a held 2-bit operation code, and digit presses carry a held BCD value.

Parameters:
SCAN_DIV, 1000, clock cycles each column stays driven; the row sample is taken on the last cycle of the dwell (must be >= 2).
DEBOUNCE, 4, consecutive agreeing samples needed to accept a press or a release (must be >= 1).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
filas  input  4  keypad rows; active-low; asynchronous to clk
columnas  output  4  column drive; active-low, one-hot-low
digito  output  4  BCD value of the last digit key; held
digito_en  output  1  one-cycle strobe, digit key accepted
operando_en  output  1  one-cycle strobe, operator key accepted
que_operacion  output  2  last operator code; held; 00 suma, 01 resta, 10 mult, 11 div
igual_en  output  1  one-cycle strobe, '#' accepted
borrar_en  output  1  one-cycle strobe, '*' accepted

Behaviour:
- Keymap, listed as row r / column c, left to right per row:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
  - A=suma, B=resta, C=mult, D=div, #=igual, *=borrar.
- Row input: filas passes through a 2-flop synchroniser; both flops reset to 4'b1111.
- Column drive: columnas = ~(4'b0001 << col_idx).
- Scan divider: counts 0..SCAN_DIV-1 and wraps continuously; "sample" means the terminal-count cycle.
- col_idx advances (mod 4, 3 wraps to 0) only on a sample in ESCANEAR with no row low, or on leaving VALIDAR/ESPERAR_SOLTAR. It is frozen otherwise.
- Multiple rows low: the lowest row index wins. Other columns are not examined while frozen.
- FSM states:
  - ESCANEAR: on a sample with any synced row low, capture (col_idx, row) as the candidate, set deb_cnt=1 and go to VALIDAR. If DEBOUNCE==1, go directly to EMITIR instead.
  - VALIDAR: on each sample, if the candidate row is still the lowest low row, increment deb_cnt. When it reaches DEBOUNCE, go to EMITIR. Any disagreeing sample goes to ESCANEAR, advances the column and emits nothing.
  - EMITIR: lasts exactly one cycle. Assert exactly one strobe from the candidate's decode.
    - Digit key: load digito.
    - Operator key: load que_operacion in the same cycle as operando_en.
    - Then go to ESPERAR_SOLTAR and clear rel_cnt.
  - ESPERAR_SOLTAR: on each sample with all synced rows high, increment rel_cnt; any sample with a row low clears rel_cnt. When rel_cnt reaches DEBOUNCE, go to ESCANEAR and advance the column.
- Key held or extra keys pressed: no further strobes while held. Keys pressed during ESPERAR_SOLTAR are ignored until a full release is accepted.
- Held outputs: digito and que_operacion change only in EMITIR for their key class; all other events leave them unchanged.
- Strobes: all are 0 outside EMITIR, and at most one is high in any cycle.
- Latency: the strobe is asserted on the cycle after the DEBOUNCE-th agreeing sample. For a press held steadily, that is (DEBOUNCE-1)*SCAN_DIV+1 cycles after the first detecting sample, plus 2 cycles of synchroniser delay.
- Reset values:
  - state ESCANEAR, col_idx 0, columnas 4'b1110
  - divider, deb_cnt and rel_cnt all 0
  - digito 4'd0, que_operacion 2'b00, all strobes 0
- Reset mid-operation (any state): all of the above apply on the next edge. A key still held after reset is detected afresh and produces a new strobe after debounce; this is required behaviour.
- Counter widths: $clog2 of the respective parameter plus 1. There is no overflow path, because the counters saturate at the state transition.

Test Plan:
1. Bench parameters SCAN_DIV=4, DEBOUNCE=3. Assert reset for 3 cycles -> columnas=4'b1110, all strobes 0, digito=0, que_operacion=00; after release, columnas cycles 1110->1101->1011->0111->1110 every 4 cycles.
2. Hold '5' (row1 low while columnas=1101) for 200 cycles -> exactly one digito_en pulse with digito=5 in that cycle and held afterwards; columnas frozen at 1101 while held.
3. Press and release 'C', then press '#' -> operando_en pulse with que_operacion=10 in the same cycle, then one igual_en pulse; que_operacion stays 10 and digito is unchanged.
4. Bounce: row0 low for only one sample on column 0 -> no strobe; FSM returns to ESCANEAR and columnas advances to 1101.
5. Hold '1' and '4' together (column 0, rows 0 and 1) -> one digito_en pulse with digito=1. Release with a one-sample low glitch mid-release -> no second pulse; a re-press after full release gives a second pulse.
6. Hold '*', assert reset during ESPERAR_SOLTAR -> outputs return to reset values; after reset, exactly one borrar_en pulse follows the debounce latency while '*' is still held.
